// File: rtl/cernbe_arb_pkg.sv
// cernbe_arb_pkg: shared types and constants for the two-master bus arbiter
package cernbe_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {RD, WR} kind_t;
  typedef logic mst_t;
  localparam logic [63:0] ERR_DATA = '1;
endpackage

// File: rtl/cernbe_req_capture.sv
// cernbe_req_capture: one master's request latch, pending flag and sticky overrun
module cernbe_req_capture
  import cernbe_arb_pkg::*;
#(
  parameter int AW = 20,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd,
  input  logic          i_wr,
  input  logic          i_clr,
  output logic          o_pending,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_wdata,
  output kind_t         o_kind,
  output logic          o_overrun
);
  logic          r_pending;
  logic          r_overrun;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  kind_t         r_kind;
  logic          w_stb;
  logic          w_take;
  assign w_stb  = i_rd | i_wr;
  assign w_take = w_stb & ~r_pending;
  // latch a strobe only when idle; a strobe on a pending slot is dropped and flagged
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_kind    <= RD;
    end else begin
      if (w_take) begin
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_kind  <= i_wr ? WR : RD;
      end
      r_pending <= w_take | (r_pending & ~i_clr);
      r_overrun <= r_overrun | (w_stb & r_pending);
    end
  end
  assign o_pending = r_pending;
  assign o_overrun = r_overrun;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;
  assign o_kind    = r_kind;
endmodule

// File: rtl/cernbe_bus_arbiter.sv
// cernbe_bus_arbiter: round-robin two-master to one-slave memory bus arbiter with watchdog
module cernbe_bus_arbiter
  import cernbe_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH-1:0] m0_VMEAddr_i,
  input  logic [DATA_WIDTH-1:0] m0_VMEWrData_i,
  input  logic                  m0_VMERdMem_i,
  input  logic                  m0_VMEWrMem_i,
  output logic [DATA_WIDTH-1:0] m0_VMERdData_o,
  output logic                  m0_VMERdDone_o,
  output logic                  m0_VMEWrDone_o,
  output logic                  m0_Error_o,
  input  logic [ADDR_WIDTH-1:0] m1_VMEAddr_i,
  input  logic [DATA_WIDTH-1:0] m1_VMEWrData_i,
  input  logic                  m1_VMERdMem_i,
  input  logic                  m1_VMEWrMem_i,
  output logic [DATA_WIDTH-1:0] m1_VMERdData_o,
  output logic                  m1_VMERdDone_o,
  output logic                  m1_VMEWrDone_o,
  output logic                  m1_Error_o,
  output logic [ADDR_WIDTH-1:0] VMEAddr_o,
  output logic [DATA_WIDTH-1:0] VMEWrData_o,
  output logic                  VMERdMem_o,
  output logic                  VMEWrMem_o,
  input  logic [DATA_WIDTH-1:0] VMERdData_i,
  input  logic                  VMERdDone_i,
  input  logic                  VMEWrDone_i,
  output logic [1:0]            overrun_o
);
  localparam logic [DATA_WIDTH-1:0] ERR_WORD = ERR_DATA[DATA_WIDTH-1:0];
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [1:0]            w_pend;
  logic [1:0]            w_clr;
  logic [ADDR_WIDTH-1:0] w_cap_addr  [2];
  logic [DATA_WIDTH-1:0] w_cap_wdata [2];
  kind_t                 w_cap_kind  [2];

  for (genvar g = 0; g < 2; g++) begin : g_cap
    cernbe_req_capture #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_cap (
      .Clk       (Clk),
      .Rst       (Rst),
      .i_addr    ((g == 1) ? m1_VMEAddr_i   : m0_VMEAddr_i),
      .i_wdata   ((g == 1) ? m1_VMEWrData_i : m0_VMEWrData_i),
      .i_rd      ((g == 1) ? m1_VMERdMem_i  : m0_VMERdMem_i),
      .i_wr      ((g == 1) ? m1_VMEWrMem_i  : m0_VMEWrMem_i),
      .i_clr     (w_clr[g]),
      .o_pending (w_pend[g]),
      .o_addr    (w_cap_addr[g]),
      .o_wdata   (w_cap_wdata[g]),
      .o_kind    (w_cap_kind[g]),
      .o_overrun (overrun_o[g])
    );
  end

  state_t                r_state, w_state;
  mst_t                  r_grant, w_grant;
  mst_t                  r_last, w_last;
  logic [15:0]           r_wd, w_wd;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
  logic                  r_rd, w_rd;
  logic                  r_wr, w_wr;
  logic [DATA_WIDTH-1:0] r_rdata [2];
  logic [DATA_WIDTH-1:0] w_rdata [2];
  logic [1:0]            r_rdone, w_rdone;
  logic [1:0]            r_wdone, w_wdone;
  logic [1:0]            r_err, w_err;
  mst_t                  w_sel;
  kind_t                 w_kind;
  logic                  w_done;

  assign w_sel  = (w_pend[0] & w_pend[1]) ? ~r_last : w_pend[1];
  assign w_kind = w_cap_kind[r_grant];
  assign w_done = (w_kind == WR) ? VMEWrDone_i : VMERdDone_i;

  // next-state, slave drive and response routing; every output is registered
  always_comb begin
    w_state = r_state;
    w_grant = r_grant;
    w_last  = r_last;
    w_wd    = r_wd;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_rdata = r_rdata;
    w_rdone = '0;
    w_wdone = '0;
    w_err   = '0;
    w_clr   = '0;
    case (r_state)
      IDLE: if (|w_pend) begin
        w_state = ISSUE;
        w_grant = w_sel;
        w_addr  = w_cap_addr[w_sel];
        w_wdata = w_cap_wdata[w_sel];
        w_rd    = w_cap_kind[w_sel] == RD;
        w_wr    = w_cap_kind[w_sel] == WR;
      end
      ISSUE: begin
        w_state = WAIT;
        w_wd    = '0;
      end
      WAIT: if (w_done || r_wd == WD_LAST) begin
        w_state          = IDLE;
        w_last           = r_grant;
        w_clr[r_grant]   = 1'b1;
        w_rdone[r_grant] = w_kind == RD;
        w_wdone[r_grant] = w_kind == WR;
        w_err[r_grant]   = ~w_done;
        w_rdata[r_grant] = !w_done ? ERR_WORD : (w_kind == RD ? VMERdData_i : r_rdata[r_grant]);
      end else begin
        w_wd = r_wd + 16'd1;
      end
      default: w_state = IDLE;
    endcase
  end

  // state and output registers; reset aborts any transaction silently
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= IDLE;
      r_grant    <= 1'b0;
      r_last     <= 1'b1;
      r_wd       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
      r_rdone    <= '0;
      r_wdone    <= '0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state;
      r_grant    <= w_grant;
      r_last     <= w_last;
      r_wd       <= w_wd;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_rd       <= w_rd;
      r_wr       <= w_wr;
      r_rdata[0] <= w_rdata[0];
      r_rdata[1] <= w_rdata[1];
      r_rdone    <= w_rdone;
      r_wdone    <= w_wdone;
      r_err      <= w_err;
    end
  end

  assign VMEAddr_o      = r_addr;
  assign VMEWrData_o    = r_wdata;
  assign VMERdMem_o     = r_rd;
  assign VMEWrMem_o     = r_wr;
  assign m0_VMERdData_o = r_rdata[0];
  assign m1_VMERdData_o = r_rdata[1];
  assign m0_VMERdDone_o = r_rdone[0];
  assign m1_VMERdDone_o = r_rdone[1];
  assign m0_VMEWrDone_o = r_wdone[0];
  assign m1_VMEWrDone_o = r_wdone[1];
  assign m0_Error_o     = r_err[0];
  assign m1_Error_o     = r_err[1];
endmodule
